// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: sequencer for an external bank of WIDTH JK flip-flops.
// Drives per-bit J/K so the bank clears, loads in parallel, or counts
// N steps up or down. The bank has no reset, so it is cleared while this
// block sits in INIT.
//
// Ports:
//   Clk        clock; the bank and this block sample on the rising edge
//   Rst_b      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  command accepted on cmd_valid && cmd_ready at a rising edge
//   cmd_op     00 COUNT_UP, 01 COUNT_DOWN, 10 LOAD, 11 CLEAR
//   cmd_data   LOAD value in [WIDTH-1:0]; COUNT step count in [CNTW-1:0]
//   abort      cancels an in-progress COUNT_UP/COUNT_DOWN
//   Q          current bank state
//   J, K       per-bit drive to the bank
//   busy       high in every state except IDLE
//   tc         one-cycle pulse after a counter wrap
module jk_bank_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8,
  localparam int DW   = (WIDTH > CNTW) ? WIDTH : CNTW
) (
  input  logic             Clk,
  input  logic             Rst_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DW-1:0]    cmd_data,
  input  logic             abort,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_UP,
    S_DOWN
  } state_t;

  typedef enum logic [1:0] {
    OP_UP    = 2'b00,
    OP_DOWN  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  state_t           state;
  logic [CNTW-1:0]  rem;
  logic [WIDTH-1:0] ldval;
  logic [WIDTH-1:0] m_up;
  logic [WIDTH-1:0] m_down;
  logic [CNTW-1:0]  n_steps;

  assign n_steps   = cmd_data[CNTW-1:0];
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    m_up      = '0;
    m_down    = '0;
    m_up[0]   = 1'b1;
    m_down[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      m_up[i]   = m_up[i-1] & Q[i-1];
      m_down[i] = m_down[i-1] & ~Q[i-1];
    end
  end

  always_comb begin
    J = '0;
    K = '0;
    case (state)
      S_INIT, S_CLR: begin
        J = '0;
        K = '1;
      end
      S_LOAD: begin
        J = ldval;
        K = ~ldval;
      end
      S_UP: begin
        if (!abort) begin
          J = m_up;
          K = m_up;
        end
      end
      S_DOWN: begin
        if (!abort) begin
          J = m_down;
          K = m_down;
        end
      end
      default: begin
        J = '0;
        K = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_b) begin
    if (!Rst_b) begin
      state <= S_INIT;
      rem   <= '0;
      ldval <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        S_INIT: state <= S_IDLE;
        S_IDLE: begin
          if (cmd_valid) begin
            case (op_t'(cmd_op))
              OP_LOAD: begin
                ldval <= cmd_data[WIDTH-1:0];
                state <= S_LOAD;
              end
              OP_CLEAR: state <= S_CLR;
              OP_UP, OP_DOWN: begin
                // A zero-length count is consumed without leaving IDLE.
                if (n_steps != '0) begin
                  rem   <= n_steps;
                  state <= (cmd_op == OP_UP) ? S_UP : S_DOWN;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_LOAD, S_CLR: state <= S_IDLE;
        S_UP, S_DOWN: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            rem <= rem - 1'b1;
            tc  <= (state == S_UP) ? (&Q) : ~(|Q);
            if (rem == CNTW'(1)) state <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Sequencer for an external bank of WIDTH JK flip-flops. The bank has one JK cell per bit, driven by J[i]/K[i] and returning Q[i].
- Generates per-bit J/K drive so the bank performs clear, parallel load, and N-step up or down counting.
- Commands arrive over a valid/ready handshake; an abort input cancels an in-progress count.
- The JK cells have no reset of their own, so this block also clears the bank after reset.

Parameters:
WIDTH, 4, number of JK cells in the bank (Q/J/K width)
CNTW, 8, width of the step-count field in cmd_data

Ports:
Clk  in  1  clock; the bank and this block both sample on the rising edge
Rst_b  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
cmd_op  in  2  00 COUNT_UP, 01 COUNT_DOWN, 10 LOAD, 11 CLEAR
cmd_data  in  max(WIDTH,CNTW)  LOAD: value in [WIDTH-1:0]; COUNT: step count N in [CNTW-1:0]; CLEAR: ignored
abort  in  1  cancels COUNT_UP/COUNT_DOWN
Q  in  WIDTH  current bank state
J  out  WIDTH  J drive to the bank
K  out  WIDTH  K drive to the bank
busy  out  1  high in every state except IDLE
tc  out  1  registered one-cycle pulse on counter wrap

Behaviour:
- States: INIT, IDLE, LOAD, CLR, UP, DOWN. Registers: state, rem[CNTW-1:0], ldval[WIDTH-1:0], tc.
- Rst_b low (async): state=INIT, rem=0, ldval=0, tc=0.
- INIT: J=0, K=all ones, so the bank clears on every edge while reset is held. cmd_ready=0, busy=1.
- INIT exit: first rising edge with Rst_b high goes to IDLE.
- J/K are combinational from state, Q, ldval and abort:
  - IDLE: J=K=0 (hold).
  - LOAD: J=ldval, K=~ldval.
  - CLR: J=0, K=all ones.
  - UP: J=K=m, where m[0]=1 and m[i]=&Q[i-1:0].
  - DOWN: J=K=m, where m[0]=1 and m[i]=~|Q[i-1:0].
  - UP/DOWN with abort=1: J=K=0.
- cmd_ready=1 only in IDLE.
- Accept in IDLE (cmd_valid=1):
  - LOAD: ldval<=cmd_data[WIDTH-1:0], go to LOAD.
  - CLEAR: go to CLR.
  - COUNT with N=cmd_data[CNTW-1:0]: N=0 stays in IDLE (no-op, no step). N>0 sets rem<=N and goes to UP or DOWN.
- LOAD and CLR last exactly one cycle. The bank takes the new value on the edge that returns the block to IDLE.
- UP/DOWN step edge: if abort=1, no bank change and go to IDLE. Otherwise the bank steps by ±1 mod 2^WIDTH and rem<=rem-1; when rem==1 go to IDLE.
- Net effect: exactly N steps and busy high for N cycles, unless aborted.
- tc: set at a step edge where (UP and Q==all ones) or (DOWN and Q==0), otherwise cleared. It is high for the cycle after the wrapping edge.
- Latency: a command accepted at edge E0 produces its first bank change at E0+1. The next command can be accepted at the edge after the state returns to IDLE.
- abort outside UP/DOWN is ignored.
- cmd_valid while not ready: the command is held by the sender and not consumed.
- Reset mid-command: drops the command immediately. J/K switch to clear drive, rem is lost.

Test Plan:
1. Rst_b low 3 cycles with Q unknown, release → Q=0 by release, busy=1 until first edge after release. Then IDLE with cmd_ready=1, J=K=0.
2. LOAD cmd_data=4'hA → next cycle J=1010, K=0101. Following edge Q=A, back in IDLE. Q stays A with no further commands.
3. From Q=A, COUNT_UP N=3 → Q=B,C,D on 3 consecutive edges. busy high 3 cycles, tc stays 0, cmd_ready returns after.
4. From Q=E, COUNT_UP N=3 → Q=F,0,1; tc=1 only in the cycle after the F→0 edge. Then DOWN N=2 → Q=0,F; tc pulses after the 0→F edge.
5. From Q=0, COUNT_UP N=10; abort=1 in the 3rd step cycle → Q=2 held, state IDLE next cycle, no step on the abort edge.
6. COUNT_UP N=0 → accepted, Q unchanged, busy stays 0. Then CLEAR from Q=7 → Q=0 after one cycle. Assert Rst_b low mid-COUNT_UP from Q=5 → J=0/K=all ones immediately, Q=0 at next edge, busy=1.
